// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Latency/backpressure: n/a (declarations only).
// State encoding is 2-bit so the FSM register stays narrow.
package sub_pkg;
    localparam int SUB_WIDTH = 16;
    localparam int SUB_CNT_W = $clog2(SUB_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;
endpackage

// File: rtl/serial_sub16_fs_bit.sv
// One-bit full subtractor: d = x - y - bin, bout = borrow out.
// Latency: combinational. Backpressure: none.
module fs_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end
endmodule

// File: rtl/serial_sub16.sv
// Bit-serial a - b, LSB first, with borrow/sign/zero/parity/overflow flags.
// Latency: done pulses WIDTH clocks after the accepting edge; results held until the next completion.
// Backpressure: start is ignored while busy; accepted again in IDLE or DONE.
module serial_sub16
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             sign,
    output logic             zero,
    output logic             parity,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    sub_state_t       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa, sb, sd;
    logic             bin, zacc, pacc, amsb, bmsb;
    logic             d_bit, bout_bit;
    logic             accept, last;

    fs_bit u_fs (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (bin),
        .d    (d_bit),
        .bout (bout_bit)
    );

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                accept = start;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                last = (cnt == CW'(WIDTH - 1));
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                accept    = start;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sa       <= '0;
            sb       <= '0;
            sd       <= '0;
            bin      <= 1'b0;
            zacc     <= 1'b0;
            pacc     <= 1'b0;
            amsb     <= 1'b0;
            bmsb     <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            sign     <= 1'b0;
            zero     <= 1'b0;
            parity   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sa   <= a;
                sb   <= b;
                bin  <= 1'b0;
                cnt  <= '0;
                zacc <= 1'b0;
                pacc <= 1'b0;
                amsb <= a[WIDTH-1];
                bmsb <= b[WIDTH-1];
            end else if (state == RUN) begin
                sa   <= sa >> 1;
                sb   <= sb >> 1;
                sd   <= {d_bit, sd[WIDTH-1:1]};
                bin  <= bout_bit;
                zacc <= zacc | d_bit;
                pacc <= pacc ^ d_bit;
                cnt  <= cnt + 1'b1;
                // Final bit is folded in directly so all results land on the same edge.
                if (last) begin
                    diff     <= {d_bit, sd[WIDTH-1:1]};
                    borrow   <= bout_bit;
                    sign     <= d_bit;
                    zero     <= ~(zacc | d_bit);
                    parity   <= ~(pacc ^ d_bit);
                    overflow <= (amsb ^ bmsb) & (d_bit ^ amsb);
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_sub16.sv
// Scoreboard bench for serial_sub16: stimulus queues expected results, monitor checks on done.
// Latency checked via cycle stamps; directed vectors with hand-computed results.
module tb_serial_sub16;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        busy, done;
    logic [15:0] diff;
    logic        borrow, sign, zero, parity, overflow;

    typedef struct {
        logic [15:0] diff;
        logic [4:0]  flags;   // {borrow, sign, zero, parity, overflow}
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   nerr = 0;
    int   nchk = 0;
    int   cyc  = 0;
    logic prev_done = 1'b0;

    serial_sub16 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .sign     (sign),
        .zero     (zero),
        .parity   (parity),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] flags_now();
        return {borrow, sign, zero, parity, overflow};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done cycle is matched against the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            check("done_not_back_to_back", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("diff", {16'd0, diff}, {16'd0, e.diff});
                check("flags", {27'd0, flags_now()}, {27'd0, e.flags});
                check("latency", cyc, e.cyc);
            end
        end
        prev_done <= done;
    end

    // Drive start for one cycle from a negedge; returns the cycle stamp of the accept edge.
    task automatic do_op(input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] ed, input logic [4:0] ef,
                         input bit push, output int acc);
        exp_t e;
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        acc = cyc;
        if (push) begin
            e.diff = ed;
            e.flags = ef;
            e.cyc = acc + 16;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int acc;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_diff", {16'd0, diff}, 0);
        check("reset_flags", {27'd0, flags_now()}, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: simple positive difference
        do_op(16'h0005, 16'h0003, 16'h0002, 5'b00000, 1'b1, acc);
        check("busy_in_run", {31'd0, busy}, 1);
        wait_drain("drain_t1");

        // 2: borrow through all bits
        do_op(16'h0000, 16'h0001, 16'hFFFF, 5'b11010, 1'b1, acc);
        wait_drain("drain_t2");

        // 3: signed overflow both directions
        do_op(16'h8000, 16'h0001, 16'h7FFF, 5'b00001, 1'b1, acc);
        wait_drain("drain_t3a");
        do_op(16'h7FFF, 16'hFFFF, 16'h8000, 5'b11001, 1'b1, acc);
        wait_drain("drain_t3b");

        // 4: equal operands; previous results must hold during RUN
        do_op(16'h1234, 16'h1234, 16'h0000, 5'b00110, 1'b1, acc);
        a = 16'hFFFF;
        b = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(negedge clk);
            check("hold_diff", {16'd0, diff}, 32'h8000);
            check("hold_flags", {27'd0, flags_now()}, {27'd0, 5'b11001});
        end
        wait_drain("drain_t4");

        // 5: start during RUN is ignored
        do_op(16'h0005, 16'h0003, 16'h0002, 5'b00000, 1'b1, acc);
        repeat (4) @(negedge clk);
        a = 16'h0001;
        b = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain("drain_t5");

        // 6: reset mid-run aborts with no done; rst beats start
        do_op(16'h0005, 16'h0003, 16'h0000, 5'b00000, 1'b0, acc);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_diff", {16'd0, diff}, 0);
        check("abort_flags", {27'd0, flags_now()}, 0);
        rst = 1'b0;
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_idle", {31'd0, busy}, 0);

        // start held high: accepted again straight out of DONE
        do_op(16'h00FF, 16'h0100, 16'hFFFF, 5'b11010, 1'b1, acc);
        start = 1'b1;
        a = 16'h0003;
        b = 16'h0005;
        while (cyc < acc + 17) @(negedge clk);
        start = 1'b0;
        begin
            exp_t e;
            e.diff = 16'hFFFE;
            e.flags = 5'b11000;
            e.cyc = acc + 33;
            exp_q.push_back(e);
        end
        check("b2b_busy", {31'd0, busy}, 1);
        wait_drain("drain_t6");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
